cpu2core_cpu_0_cpu_debug_master_scan: RTL and testbench

- Sysclk-domain scan master that drives the virtual-JTAG side of the Nios II debug slave from on-chip logic instead of the JTAG hub.
- Accepts one command at a time: a 2-bit IR value plus a SCAN_LEN-bit data word.
- Runs the sequence UIR -> CDR -> SDR shift -> UDR -> RTI, generating tck, tdi and the virtual-state strobes, and returns the captured tdo word.
- Sits between an embedded debug controller and the debug slave tck/sysclk pair.

---
 rtl/cpu2core_cpu_0_cpu_debug_pkg.sv | 28 ++
 rtl/cpu2core_cpu_0_cpu_debug_tck_gen.sv | 38 +++
 rtl/cpu2core_cpu_0_cpu_debug_master_scan.sv | 156 +++++++++++++++
 tb/tb_cpu2core_cpu_0_cpu_debug_master_scan.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu2core_cpu_0_cpu_debug_pkg.sv
// Shared types and constants for the sysclk-domain
// debug scan master.
package cpu2core_cpu_0_cpu_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SHIFT,
        ST_UDR,
        ST_RTI,
        ST_DONE
    } scan_state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam int unsigned DEFAULT_SCAN_LEN = 38;

    function automatic logic scan_active(
        input scan_state_t s
    );
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/cpu2core_cpu_0_cpu_debug_tck_gen.sv
// tck divider: TCK_DIV clk low, TCK_DIV clk high.
// Held at phase 0 with tck low whenever run is low.
module cpu2core_cpu_0_cpu_debug_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic period_end
);

    localparam logic [7:0] HALF_LAST = 8'(TCK_DIV - 1);

    logic [7:0] cnt;
    logic       half_end;

    assign half_end   = (cnt == HALF_LAST);
    // Next clk drives tck high.
    assign tck_rise   = run && half_end && !tck;
    // Next clk is the first of a new period.
    assign period_end = run && half_end && tck;

    // Half-period counter; tck flips at each half end.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (half_end) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/cpu2core_cpu_0_cpu_debug_master_scan.sv
// Scan master driving the debug slave virtual-JTAG
// port: UIR -> CDR -> SDR -> UDR -> RTI per command.
module cpu2core_cpu_0_cpu_debug_master_scan
    import cpu2core_cpu_0_cpu_debug_pkg::*;
#(
    parameter int unsigned SCAN_LEN   = DEFAULT_SCAN_LEN,
    parameter int unsigned TCK_DIV    = 2,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SCAN_LEN-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SCAN_LEN-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic [1:0]          ir_in,
    input  logic [1:0]          ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int CW =
        (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [CW-1:0] LAST_BIT =
        CW'(SCAN_LEN - 1);
    localparam logic [3:0] LAST_RTI =
        4'(RTI_CYCLES - 1);

    scan_state_t         state;
    logic [SCAN_LEN-1:0] sr;
    logic [CW-1:0]       bit_cnt;
    logic [3:0]          rti_cnt;
    logic                run;
    logic                tck_rise;
    logic                period_end;

    assign run = scan_active(state);

    cpu2core_cpu_0_cpu_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .tck        (tck),
        .tck_rise   (tck_rise),
        .period_end (period_end)
    );

    // Scan sequencer; every output is set one clk ahead
    // so it lands on the first clk of each tck period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_ir_out     <= '0;
            ir_in          <= '0;
            tdi            <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            sr             <= '0;
            bit_cnt        <= '0;
            rti_cnt        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state          <= ST_UIR;
                        cmd_ready      <= 1'b0;
                        ir_in          <= cmd_ir;
                        sr             <= cmd_data;
                        bit_cnt        <= '0;
                        vs_uir         <= 1'b1;
                        jtag_state_rti <= 1'b0;
                    end
                end
                ST_UIR: begin
                    if (tck_rise)
                        rsp_ir_out <= ir_out;
                    if (period_end) begin
                        state  <= ST_CDR;
                        vs_uir <= 1'b0;
                        vs_cdr <= 1'b1;
                    end
                end
                ST_CDR: begin
                    if (period_end) begin
                        state  <= ST_SHIFT;
                        vs_cdr <= 1'b0;
                        vs_sdr <= 1'b1;
                        tdi    <= sr[0];
                    end
                end
                ST_SHIFT: begin
                    if (tck_rise) begin
                        rsp_data[bit_cnt] <= tdo;
                        sr <= sr >> 1;
                    end
                    if (period_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            state  <= ST_UDR;
                            vs_sdr <= 1'b0;
                            vs_udr <= 1'b1;
                            tdi    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            tdi     <= sr[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (period_end) begin
                        state          <= ST_RTI;
                        vs_udr         <= 1'b0;
                        jtag_state_rti <= 1'b1;
                        rti_cnt        <= '0;
                    end
                end
                ST_RTI: begin
                    if (period_end) begin
                        if (rti_cnt == LAST_RTI) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            rti_cnt <= rti_cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu2core_cpu_0_cpu_debug_master_scan.sv
// Directed bench for the debug scan master, default
// build plus a TCK_DIV=5 / RTI_CYCLES=1 build.
module tb_cpu2core_cpu_0_cpu_debug_master_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'd0;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_data;
    logic [1:0]  rsp_ir_out;
    logic [1:0]  ir_in;
    logic [1:0]  ir_out = 2'd0;
    logic        tck, tdi;
    wire         tdo;
    logic        vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic        jtag_state_rti;
    logic        lb = 1'b1;
    logic        tdo_c = 1'b0;

    assign tdo = lb ? tdi : tdo_c;

    cpu2core_cpu_0_cpu_debug_master_scan dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_ir_out     (rsp_ir_out),
        .ir_in          (ir_in),
        .ir_out         (ir_out),
        .tck            (tck),
        .tdi            (tdi),
        .tdo            (tdo),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .vs_udr         (vs_udr),
        .jtag_state_rti (jtag_state_rti)
    );

    logic        c5_valid = 1'b0;
    logic        c5_ready;
    logic [1:0]  c5_ir = 2'd0;
    logic [37:0] c5_data = '0;
    logic        c5_rsp_valid;
    logic        c5_rsp_ready = 1'b1;
    logic [37:0] c5_rsp_data;
    logic [1:0]  c5_rsp_ir;
    logic [1:0]  c5_ir_in;
    logic [1:0]  c5_ir_out = 2'd0;
    logic        tck5, tdi5;
    logic        c5_uir, c5_cdr, c5_sdr, c5_udr;
    logic        c5_rti;

    cpu2core_cpu_0_cpu_debug_master_scan #(
        .SCAN_LEN   (38),
        .TCK_DIV    (5),
        .RTI_CYCLES (1)
    ) dut5 (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (c5_valid),
        .cmd_ready      (c5_ready),
        .cmd_ir         (c5_ir),
        .cmd_data       (c5_data),
        .rsp_valid      (c5_rsp_valid),
        .rsp_ready      (c5_rsp_ready),
        .rsp_data       (c5_rsp_data),
        .rsp_ir_out     (c5_rsp_ir),
        .ir_in          (c5_ir_in),
        .ir_out         (c5_ir_out),
        .tck            (tck5),
        .tdi            (tdi5),
        .tdo            (tdi5),
        .vs_uir         (c5_uir),
        .vs_cdr         (c5_cdr),
        .vs_sdr         (c5_sdr),
        .vs_udr         (c5_udr),
        .jtag_state_rti (c5_rti)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Event counters sampled shortly after each clk edge.
    int   uir_r = 0, cdr_r = 0, sdr_r = 0, udr_r = 0;
    int   tck_r = 0, udr_cyc = 0, rv_cyc = 0;
    int   edge_viol = 0;
    logic tck_q = 1'b0;
    logic [4:0] sig_q = '0;
    logic [4:0] sig;

    always @(posedge clk) begin
        #2;
        sig = {tdi, vs_uir, vs_cdr, vs_sdr, vs_udr};
        if (tck && !tck_q) begin
            tck_r++;
            if (vs_uir) uir_r++;
            if (vs_cdr) cdr_r++;
            if (vs_sdr) sdr_r++;
            if (vs_udr) udr_r++;
        end
        if (vs_udr) udr_cyc++;
        if (rsp_valid) rv_cyc++;
        if (sig != sig_q && tck) edge_viol++;
        tck_q = tck;
        sig_q = sig;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Accept one command and wait for its response.
    task automatic scan(
        input  logic [1:0]  ir,
        input  logic [37:0] d,
        input  logic        keep,
        input  logic [1:0]  nir,
        input  logic [37:0] nd,
        output int          lat,
        output int          ir_bad
    );
        cmd_ir    = ir;
        cmd_data  = d;
        cmd_valid = 1'b1;
        ir_bad    = 0;
        check("accept_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (keep) begin
            cmd_ir   = nir;
            cmd_data = nd;
        end else begin
            cmd_valid = 1'b0;
        end
        while (!rsp_valid && lat < 2000) begin
            if (ir_in !== ir) ir_bad++;
            tick;
            lat++;
        end
    endtask

    initial begin
        int lat, ir_bad, bad, k;
        int b_t, b_u, b_c, b_s, b_d, b_v, b_e;
        int runlen, hi;
        logic prev;

        repeat (3) tick;
        reset = 1'b0;
        b_t = tck_r;
        repeat (20) tick;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_ir", 64'(rsp_ir_out), 64'd0);
        check("rst_ir_in", 64'(ir_in), 64'd0);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_vs",
              64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        check("rst_rti", 64'(jtag_state_rti), 64'd1);
        check("idle_tck_rises", 64'(tck_r - b_t), 64'd0);
        check("rst5_ready", 64'(c5_ready), 64'd1);

        // Loopback scan, rsp_ready held high throughout.
        lb = 1'b1;
        ir_out = 2'd1;
        rsp_ready = 1'b1;
        b_u = uir_r; b_c = cdr_r; b_s = sdr_r;
        b_d = udr_r; b_e = edge_viol;
        scan(2'd2, 38'h2A5A5A5A5A, 1'b0, 2'd0, '0,
             lat, ir_bad);
        check("lb_latency", 64'(lat), 64'd173);
        check("lb_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lb_data", 64'(rsp_data), 64'h2A5A5A5A5A);
        check("lb_ir_out", 64'(rsp_ir_out), 64'd1);
        check("lb_ir_in", 64'(ir_bad), 64'd0);
        check("lb_uir_rises", 64'(uir_r - b_u), 64'd1);
        check("lb_cdr_rises", 64'(cdr_r - b_c), 64'd1);
        check("lb_sdr_rises", 64'(sdr_r - b_s), 64'd38);
        check("lb_udr_rises", 64'(udr_r - b_d), 64'd1);
        check("lb_edge_viol", 64'(edge_viol - b_e), 64'd0);
        tick;
        check("lb_retired", 64'(rsp_valid), 64'd0);
        check("lb_ready_back", 64'(cmd_ready), 64'd1);
        check("lb_data_hold", 64'(rsp_data), 64'h2A5A5A5A5A);

        // Constant slave, busy command pending, stall.
        lb = 1'b0;
        tdo_c = 1'b1;
        ir_out = 2'd3;
        rsp_ready = 1'b0;
        scan(2'd0, 38'h0, 1'b1, 2'd1, 38'h15A5A5A5A5,
             lat, ir_bad);
        check("k_latency", 64'(lat), 64'd173);
        check("k_ir_out", 64'(rsp_ir_out), 64'd3);
        check("k_data", 64'(rsp_data), 64'h3FFFFFFFFF);
        check("k_busy_ignored", 64'(ir_bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (rsp_valid !== 1'b1) bad++;
            if (rsp_data !== 38'h3FFFFFFFFF) bad++;
            if (cmd_ready !== 1'b0) bad++;
        end
        check("stall_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        tick;
        check("release_valid", 64'(rsp_valid), 64'd0);
        check("release_ready", 64'(cmd_ready), 64'd1);
        rsp_ready = 1'b0;
        lb = 1'b1;
        b_s = sdr_r;
        tick;
        check("second_accept", 64'(cmd_ready), 64'd0);
        check("second_ir_in", 64'(ir_in), 64'd1);
        cmd_valid = 1'b0;

        // Abandon the second scan at shift bit 17.
        k = 0;
        while ((sdr_r - b_s) < 18 && k < 400) begin
            tick;
            k++;
        end
        check("reach_bit17", 64'(sdr_r - b_s), 64'd18);
        b_d = udr_cyc;
        b_v = rv_cyc;
        reset = 1'b1;
        tick;
        check("mid_rst_tck", 64'(tck), 64'd0);
        check("mid_rst_sdr", 64'(vs_sdr), 64'd0);
        check("mid_rst_rti", 64'(jtag_state_rti), 64'd1);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        repeat (200) tick;
        check("mid_rst_no_udr", 64'(udr_cyc - b_d), 64'd0);
        check("mid_rst_no_rsp", 64'(rv_cyc - b_v), 64'd0);

        rsp_ready = 1'b1;
        ir_out = 2'd2;
        scan(2'd1, 38'h15A5A5A5A5, 1'b0, 2'd0, '0,
             lat, ir_bad);
        check("after_latency", 64'(lat), 64'd173);
        check("after_data", 64'(rsp_data), 64'h15A5A5A5A5);
        check("after_ir_out", 64'(rsp_ir_out), 64'd2);
        check("after_ir_in", 64'(ir_bad), 64'd0);
        tick;

        // TCK_DIV=5, RTI_CYCLES=1 build.
        c5_ir = 2'd3;
        c5_data = 38'h0123456789;
        c5_valid = 1'b1;
        check("d5_ready", 64'(c5_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        c5_valid = 1'b0;
        prev = 1'b0;
        runlen = 0;
        bad = 0;
        hi = 0;
        while (lat < 2000) begin
            if (tck5 !== prev) begin
                if (runlen != 5) bad++;
                if (prev) hi++;
                runlen = 1;
                prev = tck5;
            end else begin
                runlen++;
            end
            if (c5_rsp_valid) break;
            tick;
            lat++;
        end
        check("d5_latency", 64'(lat), 64'd421);
        check("d5_phase_len", 64'(bad), 64'd0);
        check("d5_high_runs", 64'(hi), 64'd42);
        check("d5_data", 64'(c5_rsp_data), 64'h0123456789);
        check("d5_ir_in", 64'(c5_ir_in), 64'd3);

        check("edge_viol_total", 64'(edge_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
